// File: rtl/sid_bus_master.sv
// SID bus initiator: derives phi2 from clk, sequences res_n, and runs one register
// access per phi2 period from a one-entry request buffer. Optional macro: SID_BUS_MASTER_CS2_EN.
module sid_bus_master #(
  parameter int CLK_DIV    = 24,
  parameter int RES_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  // Request handshake: a request transfers on any clk where req_valid & req_ready;
  // req_we/req_addr/req_data (and req_cs) must be stable while req_valid is high.
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_data,
`ifdef SID_BUS_MASTER_CS2_EN
  input  logic       req_cs,
  output logic [1:0] cs_n_o,
`else
  output logic       cs_n_o,
`endif
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       reset_req,
  output logic       phi2_o,
  output logic       res_n_o,
  output logic       r_w_n_o,
  output logic [4:0] addr_o,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i,
  output logic [1:0] dbg_state_o
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int HW = $clog2(RES_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RES_CYCLES);
`ifdef SID_BUS_MASTER_CS2_EN
  localparam int CSW = 2;
`else
  localparam int CSW = 1;
`endif

  typedef enum logic [1:0] {S_HOLD = 2'd0, S_IDLE = 2'd1, S_ACCESS = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           phi2_q, phi2_d, res_n_q, res_n_d, rst_req_q, rst_req_d;
  logic           pending_q, pending_d, pend_we_q, pend_we_d, pend_cs_q, pend_cs_d;
  logic [4:0]     pend_addr_q, pend_addr_d, addr_q, addr_d;
  logic [7:0]     pend_data_q, pend_data_d, data_q, data_d, rsp_data_q, rsp_data_d;
  logic [CSW-1:0] cs_n_q, cs_n_d;
  logic           r_w_n_q, r_w_n_d, data_oe_q, data_oe_d, rsp_valid_q, rsp_valid_d;
  logic           last, accept, run, req_cs_i;

`ifdef SID_BUS_MASTER_CS2_EN
  assign req_cs_i = req_cs;
`else
  assign req_cs_i = 1'b0;
`endif

  always_comb begin
    last        = (cnt_q == CNT_LAST);
    req_ready   = (state_q != S_HOLD) & (~pending_q | ((state_q == S_ACCESS) & last));
    accept      = req_valid & req_ready;
    cnt_d       = last ? '0 : cnt_q + CW'(1);
    phi2_d      = (cnt_d >= CNT_HALF);
    state_d     = state_q;
    hold_d      = hold_q;
    res_n_d     = res_n_q;
    rst_req_d   = rst_req_q | reset_req;
    pending_d   = pending_q;
    pend_we_d   = pend_we_q;
    pend_cs_d   = pend_cs_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    cs_n_d      = cs_n_q;
    r_w_n_d     = r_w_n_q;
    addr_d      = addr_q;
    data_d      = data_q;
    data_oe_d   = (state_q == S_ACCESS) & ~r_w_n_q & phi2_d;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    run         = 1'b0;

    if (accept) begin
      pending_d   = 1'b1;
      pend_we_d   = req_we;
      pend_cs_d   = req_cs_i;
      pend_addr_d = req_addr;
      pend_data_d = req_data;
    end

    // Every phi2 boundary decision is made on the last clk so the bus changes with cnt = 0.
    if (last) begin
      cs_n_d    = '1;
      r_w_n_d   = 1'b1;
      data_oe_d = 1'b0;
      if (state_q == S_ACCESS) begin
        pending_d = accept;
        if (r_w_n_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = data_i;
        end
      end
      if (rst_req_q) begin
        state_d   = S_HOLD;
        hold_d    = HOLD_INIT;
        res_n_d   = 1'b0;
        rst_req_d = reset_req;
      end else if (state_q == S_HOLD) begin
        hold_d = hold_q - HW'(1);
        run    = (hold_d == '0);
      end else begin
        run = 1'b1;
      end
      if (run) begin
        state_d = S_IDLE;
        res_n_d = 1'b1;
        if (pending_d) begin
          state_d = S_ACCESS;
          cs_n_d  = ~(CSW'(1) << pend_cs_d);
          r_w_n_d = ~pend_we_d;
          addr_d  = pend_addr_d;
          data_d  = pend_data_d;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      hold_q      <= HOLD_INIT;
      phi2_q      <= 1'b0;
      res_n_q     <= 1'b0;
      rst_req_q   <= 1'b0;
      pending_q   <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_cs_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      cs_n_q      <= '1;
      r_w_n_q     <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      phi2_q      <= phi2_d;
      res_n_q     <= res_n_d;
      rst_req_q   <= rst_req_d;
      pending_q   <= pending_d;
      pend_we_q   <= pend_we_d;
      pend_cs_q   <= pend_cs_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      cs_n_q      <= cs_n_d;
      r_w_n_q     <= r_w_n_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign phi2_o      = phi2_q;
  assign res_n_o     = res_n_q;
  assign cs_n_o      = cs_n_q;
  assign r_w_n_o     = r_w_n_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign data_oe     = data_oe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sid_bus_master.sv
// Bench for sid_bus_master: directed vector table and sequences plus random traffic,
// all checked each clk against a phi2-period-level model of the bus.
module tb_sid_bus_master;
  localparam int CLK_DIV    = 24;
  localparam int RES_CYCLES = 16;
  localparam int HALF       = CLK_DIV / 2;
`ifdef SID_BUS_MASTER_CS2_EN
  localparam int CSW = 2;
`else
  localparam int CSW = 1;
`endif
  localparam logic [CSW-1:0] CS_ON  = ~CSW'(1);
  localparam logic [CSW-1:0] CS_OFF = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           req_valid = 1'b0, req_we = 1'b0, reset_req = 1'b0, req_cs = 1'b0;
  logic [4:0]     req_addr = '0;
  logic [7:0]     req_data = '0, data_i = '0;
  logic           req_ready, rsp_valid, phi2_o, res_n_o, r_w_n_o, data_oe;
  logic [7:0]     rsp_data, data_o;
  logic [4:0]     addr_o;
  logic [CSW-1:0] cs_n_o;
  logic [1:0]     dbg_state;

  sid_bus_master #(.CLK_DIV(CLK_DIV), .RES_CYCLES(RES_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
`ifdef SID_BUS_MASTER_CS2_EN
    .req_cs(req_cs),
`endif
    .cs_n_o(cs_n_o),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .reset_req(reset_req),
    .phi2_o(phi2_o), .res_n_o(res_n_o), .r_w_n_o(r_w_n_o),
    .addr_o(addr_o), .data_o(data_o), .data_oe(data_oe), .data_i(data_i),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phi2-period level) ----------------
  typedef struct { logic we; logic [4:0] addr; logic [7:0] data; } req_t;

  int unsigned n = 0;  // clks since rst release
  always @(posedge clk or posedge rst)
    if (rst) n <= 0;
    else     n <= n + 1;

  req_t       waiting, active;
  bit         waiting_v = 0, active_v = 0, rsp_due = 0;
  int         hold_end = RES_CYCLES;  // first period with res_n high
  int         rr_q[$];                // periods whose end consumes a reset_req
  logic [4:0] last_addr = '0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    int c, p;
    bit rdy;
    if (rst) begin
      waiting_v = 0; active_v = 0; rsp_due = 0; hold_end = RES_CYCLES;
      rr_q.delete(); exp_q.delete(); last_addr = '0;
      chk("rst_phi2", phi2_o, 0);
      chk("rst_res_n", res_n_o, 0);
      chk("rst_cs_n", cs_n_o, CS_OFF);
      chk("rst_r_w_n", r_w_n_o, 1);
      chk("rst_addr", addr_o, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_data_oe", data_oe, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
    end else begin
      c = int'(n % CLK_DIV);
      p = int'(n / CLK_DIV);
      rsp_due = 0;
      if (c == 0 && n != 0) begin
        rsp_due = active_v && !active.we;
        for (int i = rr_q.size() - 1; i >= 0; i--)
          if (rr_q[i] == p - 1) begin
            hold_end = p + RES_CYCLES;
            rr_q.delete(i);
          end
        active_v = 0;
        if (waiting_v && p >= hold_end) begin
          active = waiting; active_v = 1; waiting_v = 0; last_addr = waiting.addr;
        end
      end
      chk("phi2", phi2_o, c >= HALF);
      chk("res_n", res_n_o, p >= hold_end);
      chk("cs_n", cs_n_o, active_v ? CS_ON : CS_OFF);
      chk("r_w_n", r_w_n_o, active_v ? !active.we : 1'b1);
      chk("addr", addr_o, last_addr);
      chk("data_oe", data_oe, active_v && active.we && c >= HALF);
      if (active_v && active.we) chk("data_o", data_o, active.data);
      rdy = (p >= hold_end) && !waiting_v && (!active_v || c == CLK_DIV - 1);
      chk("req_ready", req_ready, rdy);
      chk("rsp_valid", rsp_valid, rsp_due);
      if (rsp_due) begin
        chk("rsp_queue_size", exp_q.size(), 1);
        if (exp_q.size() != 0) chk("rsp_data", rsp_data, exp_q.pop_front());
      end
      if (c == CLK_DIV - 1 && active_v && !active.we) exp_q.push_back(data_i);
      if (req_valid && rdy) begin
        waiting = '{req_we, req_addr, req_data};
        waiting_v = 1;
      end
      if (reset_req) rr_q.push_back(c == CLK_DIV - 1 ? p + 1 : p);
    end
  end

  // ---------------- driver tasks ----------------
  bit rand_din = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_din) data_i = 8'($urandom);
  endtask

  task automatic send(input logic we, input logic [4:0] a, input logic [7:0] d);
    int t;
    t = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
    @(negedge clk);
    while (!req_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("send_accepted", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic we; logic [4:0] addr; logic [7:0] data; logic [7:0] din;
    int cs_clks; int oe_clks; int rsps; logic [7:0] rsp;
  } vec_t;
  vec_t vt[5];

  initial begin
    int cnt, rdy_hold, cs, oe, nr, addr_bad, dat_bad, rwn_bad, run, maxrun, t, res_low;
    int rise_n, cs_start;
    logic [7:0] rd;

    vt[0] = '{1'b1, 5'h18, 8'h0F, 8'h00, 24, 12, 0, 8'h00};
    vt[1] = '{1'b0, 5'h1B, 8'h00, 8'hA5, 24, 0, 1, 8'hA5};
    vt[2] = '{1'b1, 5'h00, 8'hFF, 8'h12, 24, 12, 0, 8'h00};
    vt[3] = '{1'b0, 5'h1F, 8'h44, 8'h3C, 24, 0, 1, 8'h3C};
    vt[4] = '{1'b1, 5'h05, 8'h80, 8'h00, 24, 12, 0, 8'h00};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Power-up hold
    cnt = 0; rdy_hold = 0;
    while (!res_n_o && cnt < 1000) begin
      if (req_ready) rdy_hold++;
      tick();
      cnt++;
    end
    chk("hold_res_n_low_clks", cnt, 384);
    chk("hold_ready_high_clks", rdy_hold, 0);
    chk("ready_after_hold", req_ready, 1);

    // Single transactions from the vector table
    for (int i = 0; i < 5; i++) begin
      data_i = vt[i].din;
      send(vt[i].we, vt[i].addr, vt[i].data);
      cs = 0; oe = 0; nr = 0; rd = '0; addr_bad = 0; dat_bad = 0; rwn_bad = 0;
      repeat (3 * CLK_DIV) begin
        tick();
        if (cs_n_o == CS_ON) begin
          cs++;
          if (addr_o != vt[i].addr) addr_bad++;
          if (r_w_n_o != !vt[i].we) rwn_bad++;
        end
        if (data_oe) begin
          oe++;
          if (data_o != vt[i].data) dat_bad++;
        end
        if (rsp_valid) begin
          nr++;
          rd = rsp_data;
        end
      end
      chk("vec_cs_clks", cs, vt[i].cs_clks);
      chk("vec_oe_clks", oe, vt[i].oe_clks);
      chk("vec_rsp_count", nr, vt[i].rsps);
      if (vt[i].rsps != 0) chk("vec_rsp_data", rd, vt[i].rsp);
      chk("vec_addr_errs", addr_bad, 0);
      chk("vec_data_errs", dat_bad, 0);
      chk("vec_rwn_errs", rwn_bad, 0);
    end

    // Back-to-back writes with req_valid held
    run = 0; maxrun = 0;
    fork
      begin
        send(1'b1, 5'h01, 8'h11);
        send(1'b1, 5'h02, 8'h22);
        send(1'b1, 5'h03, 8'h33);
      end
      begin
        repeat (6 * CLK_DIV) begin
          tick();
          if (cs_n_o == CS_ON) run++;
          else run = 0;
          if (run > maxrun) maxrun = run;
        end
      end
    join
    chk("b2b_cs_low_clks", maxrun, 72);

    // reset_req during a read with a second request queued
    data_i = 8'h5A;
    send(1'b0, 5'h1B, 8'h00);
    t = 0;
    while (!(cs_n_o == CS_ON && n % CLK_DIV == 5) && t < 200) begin
      tick();
      t++;
    end
    chk("rr_read_active", cs_n_o, CS_ON);
    nr = 0; rd = '0; res_low = 0; rise_n = -1; cs_start = -1;
    fork
      begin
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
      end
      send(1'b1, 5'h04, 8'h77);
      begin
        repeat (20 * CLK_DIV) begin
          tick();
          if (rsp_valid) begin
            nr++;
            rd = rsp_data;
          end
          if (!res_n_o) res_low++;
          if (res_n_o && rise_n < 0 && res_low > 0) rise_n = int'(n);
          if (cs_n_o == CS_ON && addr_o == 5'h04 && cs_start < 0) cs_start = int'(n);
        end
      end
    join
    chk("rr_rsp_count", nr, 1);
    chk("rr_rsp_data", rd, 8'h5A);
    chk("rr_res_n_low_clks", res_low, 384);
    chk("rr_queued_at_rise", cs_start, rise_n);

    // Async rst in the middle of a write
    send(1'b1, 5'h0A, 8'hC3);
    t = 0;
    while (!(cs_n_o == CS_ON && n % CLK_DIV == 14) && t < 200) begin
      tick();
      t++;
    end
    chk("arst_oe_before", data_oe, 1);
    rst = 1'b1;
    #1;
    chk("arst_data_oe", data_oe, 0);
    chk("arst_cs_n", cs_n_o, CS_OFF);
    chk("arst_res_n", res_n_o, 0);
    tick();
    tick();
    rst = 1'b0;
    cs = 0; res_low = 0;
    repeat (20 * CLK_DIV) begin
      if (cs_n_o == CS_ON) cs++;
      if (!res_n_o) res_low++;
      tick();
    end
    chk("arst_no_access_clks", cs, 0);
    chk("arst_res_n_low_clks", res_low, 384);

    // Random traffic against the model
    rand_din = 1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 30)) tick();
      if ($urandom_range(0, 39) == 0) begin
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
      end
      send(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
    end
    repeat (3 * CLK_DIV) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sid_bus_master.md
Name: sid_bus_master

Overview:
- Host-side initiator for the SID bus; drives a real or emulated SID the way a C64 CPU does.
- Generates phi2 from the 24 MHz clock and sequences res_n.
- Performs one register read or write per phi2 cycle from a valid/ready request stream, and returns read data on a response strobe.
- Used for bench/standalone playback builds in place of the host-facing responder path.

Parameters:
- CLK_DIV, 24, clk cycles per phi2 period; even, >= 4.
- RES_CYCLES, 16, phi2 periods res_n_o is held low per reset sequence; >= 10.

Ports:
- clk  input  1  system clock (clk_24 domain)
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when valid & ready
- req_we  input  1  1 = write, 0 = read
- req_addr  input  5  SID register address
- req_data  input  8  write data
- rsp_valid  output  1  one-clk read-data strobe
- rsp_data  output  8  read data, valid with rsp_valid
- reset_req  input  1  one-clk pulse; starts a SID reset sequence
- phi2_o  output  1  SID master clock
- res_n_o  output  1  SID reset, active low
- cs_n_o  output  1  chip select, active low
- r_w_n_o  output  1  read/write
- addr_o  output  5  address bus
- data_o  output  8  data bus drive value
- data_oe  output  1  data bus output enable
- data_i  input  8  data bus input (pad-synchronised by the instantiating logic)

Behaviour:
- Reset values: cnt = 0, phi2_o = 0, res_n_o = 0, cs_n_o = 1, r_w_n_o = 1, addr_o = 0, data_o = 0, data_oe = 0, req_ready = 0, rsp_valid = 0, rsp_data = 0, pending = 0, hold counter = RES_CYCLES.
- Timing:
  - cnt is free-running, 0..CLK_DIV-1, and wraps to 0.
  - phi2_o is registered and is 1 for cnt >= CLK_DIV/2.
  - "last" means cnt == CLK_DIV-1.
- States:
  - HOLD: res_n_o = 0. The hold counter decrements at each last; the block goes to IDLE at the last where the counter reaches 0, and res_n_o rises together with cnt = 0.
  - IDLE: bus idle; an access starts at cnt == 0 if pending.
  - ACCESS: lasts exactly one phi2 period, cnt 0..CLK_DIV-1.
- Request buffer:
  - One entry, named pending.
  - req_ready = !hold & (!pending | (state == ACCESS & last)).
  - A request is latched on valid & ready.
  - A request accepted at the last of an ACCESS starts the next ACCESS immediately, giving back-to-back phi2 cycles with no gap.
- ACCESS cycle:
  - cs_n_o = 0, addr_o = req_addr, r_w_n_o = !req_we, all held for cnt 0..CLK_DIV-1.
  - Write: data_o = req_data for the whole cycle; data_oe = 1 only while phi2_o = 1.
  - Read: data_oe = 0; data_i is sampled at last; rsp_data is updated and rsp_valid pulses high for one clk at the following cnt == 0.
  - Writes produce no response.
  - pending clears at last unless refilled in the same clk.
  - After the final ACCESS the bus returns to idle at cnt == 0: cs_n_o = 1, r_w_n_o = 1, data_oe = 0; addr_o and data_o hold their last values.
- reset_req:
  - Registered, then takes effect at the next cnt == 0.
  - An ACCESS in progress completes, including its read response.
  - HOLD is then re-entered with the counter reloaded.
  - A pending request that has not started is retained and issued at the first cnt == 0 after HOLD ends.
  - reset_req during HOLD reloads the counter at the next cnt == 0.
- Async rst mid-operation: all outputs go to reset values immediately; the pending request and any in-flight response are discarded; a full HOLD follows.
- rsp_valid never asserts during HOLD except for the completing read described above.

Optional Feature:
- Macro: SID_BUS_MASTER_CS2_EN.
- Defined:
  - Adds input req_cs (1 bit) and widens cs_n_o to 2 bits.
  - An ACCESS drives cs_n_o[req_cs] = 0 and the other bit = 1; both bits are 1 when idle and in reset.
  - req_cs is latched with the request.
- Undefined: single cs_n_o, no req_cs port.

Test Plan (CLK_DIV = 24, RES_CYCLES = 16):
- Release rst, no requests -> res_n_o low for exactly 384 clks, then high; phi2_o 12 clks low / 12 clks high; req_ready 0 during HOLD, 1 after.
- Write addr 0x18 data 0x0F -> cs_n_o low and r_w_n_o 0 for 24 clks from cnt 0; addr_o = 0x18; data_oe high cnt 12..23 with data_o = 0x0F; no rsp_valid.
- Read addr 0x1B with data_i = 0xA5 -> cs_n_o low 24 clks, r_w_n_o 1, data_oe 0; single rsp_valid pulse at the next cnt 0 with rsp_data = 0xA5.
- Three writes with req_valid held high -> three consecutive ACCESS phi2 periods with cs_n_o low for 72 clks continuously; addr_o changes at each cnt 0.
- reset_req at cnt 5 of a read, plus a second request queued -> read completes and returns rsp_valid; res_n_o low 16 periods; queued request issued at the first cnt 0 after res_n_o rises.
- Async rst at cnt 14 of a write -> data_oe, cs_n_o and res_n_o take reset values in the same clk; the request is not completed after reset.
